// File: rtl/register_file_writer.sv
// ----------------------------------------------------------------------------
// register_file_writer
//
// Write side of the 32-entry integer register file of the single-cycle
// RISC-V core. Decodes the write address to one-hot enables, applies a
// byte-masked write-back to the 31 writable registers (x0 is hardwired to
// zero) and exports all registers flattened for the read-side 32:1 muxes.
// Also keeps debug bookkeeping: a sticky written-map, a saturating count of
// effective writes and the last effectively written address.
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   write_enable        commit a write-back this cycle
//   write_address[4:0]  destination register index
//   write_data[W-1:0]   write-back value
//   byte_mask[W/8-1:0]  per-byte write strobe, bit i covers bits [8i+7:8i]
//   clear_all           synchronous clear of registers and bookkeeping
//   registers_flat      register k at bits [k*WIDTH +: WIDTH]
//   written_map[31:0]   sticky bit k set once register k was written
//   write_count         number of effective writes, saturating
//   last_write_address  index of the most recent effective write
// ----------------------------------------------------------------------------
module register_file_writer #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   write_enable,
    input  logic [4:0]             write_address,
    input  logic [WIDTH-1:0]       write_data,
    input  logic [WIDTH/8-1:0]     byte_mask,
    input  logic                   clear_all,
    output logic [32*WIDTH-1:0]    registers_flat,
    output logic [31:0]            written_map,
    output logic [COUNT_WIDTH-1:0] write_count,
    output logic [4:0]             last_write_address
);

    localparam int NBYTES = WIDTH / 8;

    // Merge new data into an old word under a bit-level mask.
    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_val,
        input logic [WIDTH-1:0] new_val,
        input logic [WIDTH-1:0] bit_mask
    );
        return (old_val & ~bit_mask) | (new_val & bit_mask);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(
        input logic [COUNT_WIDTH-1:0] val
    );
        if (&val) return val;
        return val + 1'b1;
    endfunction

    logic [31:0]            dec_enable;
    logic [WIDTH-1:0]       bit_mask;
    logic                   eff_write;

    // x0 has no storage; only x1..x31 are flops.
    logic [WIDTH-1:0]       regs_q [1:31];
    logic [WIDTH-1:0]       regs_d [1:31];
    logic [31:1]            map_q, map_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [4:0]             last_q, last_d;

    always_comb begin
        for (int k = 0; k < 32; k++) begin
            dec_enable[k] = write_enable && (write_address == 5'(k));
        end
    end

    always_comb begin
        for (int b = 0; b < NBYTES; b++) begin
            bit_mask[b*8 +: 8] = {8{byte_mask[b]}};
        end
    end

    // A write counts only if it targets x1..x31 with at least one strobe.
    assign eff_write = write_enable && !dec_enable[0] && (|byte_mask);

    always_comb begin
        for (int k = 1; k < 32; k++) begin
            regs_d[k] = regs_q[k];
        end
        map_d   = map_q;
        count_d = count_q;
        last_d  = last_q;

        // clear_all wins over a simultaneous write, which is dropped.
        if (clear_all) begin
            for (int k = 1; k < 32; k++) begin
                regs_d[k] = '0;
            end
            map_d   = '0;
            count_d = '0;
            last_d  = '0;
        end else if (eff_write) begin
            for (int k = 1; k < 32; k++) begin
                if (dec_enable[k]) begin
                    regs_d[k] = merge_bytes(regs_q[k], write_data, bit_mask);
                    map_d[k]  = 1'b1;
                end
            end
            count_d = sat_inc(count_q);
            last_d  = write_address;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k < 32; k++) begin
                regs_q[k] <= '0;
            end
            map_q   <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            for (int k = 1; k < 32; k++) begin
                regs_q[k] <= regs_d[k];
            end
            map_q   <= map_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign registers_flat[0 +: WIDTH] = '0;
    for (genvar k = 1; k < 32; k++) begin : g_flat
        assign registers_flat[k*WIDTH +: WIDTH] = regs_q[k];
    end

    assign written_map        = {map_q, 1'b0};
    assign write_count        = count_q;
    assign last_write_address = last_q;

endmodule

// File: tb/tb_register_file_writer.sv
module tb_register_file_writer;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          we;
    logic [4:0]    wa;
    logic [31:0]   wd;
    logic [3:0]    bm;
    logic          clr;

    logic [1023:0] flat,  flat4;
    logic [31:0]   map,   map4;
    logic [15:0]   cnt;
    logic [3:0]    cnt4;
    logic [4:0]    last,  last4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_file_writer #(.WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .write_enable(we), .write_address(wa),
        .write_data(wd), .byte_mask(bm), .clear_all(clr),
        .registers_flat(flat), .written_map(map), .write_count(cnt),
        .last_write_address(last)
    );

    register_file_writer #(.WIDTH(32), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .write_enable(we), .write_address(wa),
        .write_data(wd), .byte_mask(bm), .clear_all(clr),
        .registers_flat(flat4), .written_map(map4), .write_count(cnt4),
        .last_write_address(last4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read-side 32:1 mux model.
    function automatic logic [31:0] mux32(input logic [1023:0] f, input logic [4:0] sel);
        return f[int'(sel)*32 +: 32];
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d; bm = m;
        @(posedge clk);
        #1;
        we = 1'b0; wa = '0; wd = '0; bm = '0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("%s_x%0d", tag, k), 64'(mux32(flat, 5'(k))), 64'h0);
        end
        chk({tag, "_map"},  64'(map),  64'h0);
        chk({tag, "_cnt"},  64'(cnt),  64'h0);
        chk({tag, "_last"}, 64'(last), 64'h0);
    endtask

    initial begin
        reset_n = 1'b0; we = 1'b0; wa = '0; wd = '0; bm = '0; clr = 1'b0;
        #2;
        chk_all_zero("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Write x5, then asynchronous reset mid-cycle
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        chk("x5_pre_rst",  64'(mux32(flat, 5'd5)), 64'hDEADBEEF);
        chk("cnt_pre_rst", 64'(cnt), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");

        // Write held across an edge while in reset never lands
        @(negedge clk);
        we = 1'b1; wa = 5'd6; wd = 32'h66; bm = 4'hF;
        @(posedge clk);
        #1;
        we = 1'b0;
        chk("x6_in_rst",  64'(mux32(flat, 5'd6)), 64'h0);
        chk("cnt_in_rst", 64'(cnt), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wr(5'd6, 32'h77, 4'hF);
        chk("x6_after_rst",  64'(mux32(flat, 5'd6)), 64'h77);
        chk("cnt_after_rst", 64'(cnt), 64'd1);

        // Full write and x0
        do_clear();
        chk_all_zero("clr1");
        wr(5'd7, 32'hA5A5_1234, 4'b1111);
        chk("x7_full",  64'(mux32(flat, 5'd7)), 64'hA5A5_1234);
        chk("map_x7",   64'(map),  64'h0000_0080);
        chk("cnt_x7",   64'(cnt),  64'd1);
        chk("last_x7",  64'(last), 64'd7);
        wr(5'd0, 32'hFFFF_FFFF, 4'b1111);
        chk("x0_zero",  64'(mux32(flat, 5'd0)), 64'h0);
        chk("map_x0",   64'(map),  64'h0000_0080);
        chk("cnt_x0",   64'(cnt),  64'd1);
        chk("last_x0",  64'(last), 64'd7);

        // Byte mask
        wr(5'd3, 32'h1122_3344, 4'b1111);
        chk("x3_pre",   64'(mux32(flat, 5'd3)), 64'h1122_3344);
        wr(5'd3, 32'hAABB_CCDD, 4'b0101);
        chk("x3_mask",  64'(mux32(flat, 5'd3)), 64'h11BB_33DD);
        chk("cnt_mask", 64'(cnt),  64'd3);
        chk("map_mask", 64'(map),  64'h0000_0088);
        wr(5'd3, 32'h0BAD_F00D, 4'b0000);
        chk("x3_nomask",   64'(mux32(flat, 5'd3)), 64'h11BB_33DD);
        chk("cnt_nomask",  64'(cnt),  64'd3);
        chk("last_nomask", 64'(last), 64'd3);

        // Same-cycle read returns old value; new value the cycle after
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 32'h9999_0000; bm = 4'b1100;
        #1;
        chk("x3_no_bypass", 64'(mux32(flat, 5'd3)), 64'h11BB_33DD);
        @(posedge clk);
        #1;
        we = 1'b0; bm = '0;
        chk("x3_hi_mask", 64'(mux32(flat, 5'd3)), 64'h9999_33DD);

        // Clear vs. write
        @(negedge clk);
        clr = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h55; bm = 4'hF;
        @(posedge clk);
        #1;
        clr = 1'b0; we = 1'b0;
        chk_all_zero("clr_wr");
        wr(5'd9, 32'h55, 4'hF);
        chk("x9_after_clr",   64'(mux32(flat, 5'd9)), 64'h55);
        chk("cnt_after_clr",  64'(cnt),  64'd1);
        chk("map_after_clr",  64'(map),  64'h0000_0200);
        chk("last_after_clr", 64'(last), 64'd9);

        // Write sweep x1..x31; narrow counter saturates at 15
        do_clear();
        chk("cnt4_clr", 64'(cnt4), 64'd0);
        for (int k = 1; k < 32; k++) begin
            wr(5'(k), 32'(k + 32'h100), 4'hF);
            if (k == 14) chk("cnt4_14", 64'(cnt4), 64'd14);
            if (k == 15) chk("cnt4_15", 64'(cnt4), 64'd15);
            if (k == 16) chk("cnt4_16", 64'(cnt4), 64'd15);
            if (k == 20) chk("cnt4_20", 64'(cnt4), 64'd15);
        end
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("sweep_x%0d", k), 64'(mux32(flat, 5'(k))),
                (k == 0) ? 64'h0 : 64'(k + 'h100));
        end
        chk("sweep_map",  64'(map),  64'hFFFF_FFFE);
        chk("sweep_cnt",  64'(cnt),  64'd31);
        chk("sweep_last", 64'(last), 64'd31);
        chk("cnt4_31",    64'(cnt4), 64'd15);
        chk("map4_sweep", 64'(map4), 64'hFFFF_FFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_writer.md
Name: register_file_writer

Overview:
- Write side of the 32-entry integer register file for the single-cycle RISC-V core.
- Decodes a 5-bit write address into 32 one-hot enables and holds the 32 architectural registers.
- Applies byte-masked write-back and exports every register flattened, so the read-side 32:1 multiplexers can select from it.
- Also keeps write bookkeeping for debug and verification: a written-map, a write counter and the last address written.

Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8.
- COUNT_WIDTH, 16, width of the saturating write counter.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- write_enable  input  1  commit a write-back this cycle
- write_address  input  5  destination register index
- write_data  input  WIDTH  write-back value
- byte_mask  input  WIDTH/8  per-byte write strobe; bit i covers bits [8i+7:8i]
- clear_all  input  1  synchronous clear of all registers and bookkeeping
- registers_flat  output  32*WIDTH  register k at bits [k*WIDTH+WIDTH-1 : k*WIDTH]
- written_map  output  32  sticky bit k set once register k has been effectively written
- write_count  output  COUNT_WIDTH  number of effective writes, saturating
- last_write_address  output  5  index of the most recent effective write

Behaviour:
- **Reset:** reset_n low asynchronously forces all registers, written_map, write_count and last_write_address to 0. Outputs stay at 0 while reset_n is low.
- **Decode:** one-hot enable[k] = write_enable & (write_address == k). The enable is combinational; all state updates on the rising edge of clk.
- **Effective write:** write_enable=1, write_address!=0 and byte_mask!=0. On the edge:
  - Selected register bytes whose mask bit is 1 take write_data; unmasked bytes hold.
  - written_map[addr] is set to 1.
  - write_count increments by 1 unless it already equals all-ones (saturate, no wrap).
  - last_write_address takes write_address.
- **Register x0:** hardwired 0.
  - Writes to address 0 are discarded.
  - written_map[0] is constantly 0.
  - A write to x0 is not counted and does not update last_write_address.
- **Empty mask:** byte_mask==0 with write_enable=1 is a no-op: no data change and no bookkeeping update.
- **Latency:** registers_flat reflects a write on the cycle after the edge; there is no internal write-to-read bypass. A read of the address being written in the same cycle returns the old value.
- **clear_all=1 on an edge:**
  - Zeroes all registers, written_map, write_count and last_write_address.
  - Takes priority over a simultaneous write, which is dropped entirely.
- **Mid-operation reset:** reset_n asserted in the same cycle as a write means the write never lands. The first edge after reset_n deasserts behaves normally.
- **Address range:** the address is a 5-bit index, so every value is valid; there is no out-of-range case.
- **Outputs:** all outputs are driven directly from flops, with no combinational path from inputs to outputs.

Test Plan:
- **Reset:** reset_n low mid-run after writing 0xDEADBEEF to x5 → registers_flat all 0, written_map=0, write_count=0, last_write_address=0, all asynchronously before the next clk edge.
- **Full write and x0:**
  - Write 0xA5A5_1234 to x7 with mask 4'b1111 → next cycle register 7=0xA5A5_1234, written_map=0x0000_0080, write_count=1, last_write_address=7.
  - Then write 0xFFFF_FFFF to x0 → register 0 stays 0, count stays 1, last address stays 7.
- **Byte mask:**
  - x3 preloaded with 0x1122_3344; write 0xAABB_CCDD with mask 4'b0101 → x3=0x11BB_33DD.
  - Then a write with mask 4'b0000 → x3 unchanged, count unchanged.
- **Clear vs. write:** clear_all=1 together with a write of 0x55 to x9 → all registers 0, written_map=0, write_count=0. The next-cycle write of 0x55 to x9 lands, count=1.
- **Write sweep:**
  - Write value k+0x100 to each x1..x31 on consecutive cycles → registers_flat slice k equals k+0x100, written_map=0xFFFF_FFFE, write_count=31, last_write_address=31.
  - Each read-side Mux_32to1 select returns the matching slice.
- **Counter saturation:** with COUNT_WIDTH=4, perform 20 effective writes → write_count stops at 15 and does not wrap.
